// File: rtl/alu_mp_sequencer.sv
// Multi-precision sequencer: issues one ALU word op per cycle LSW->MSW, chains carry, holds result until Ack.
// Optional macro ALU_SEQ_CARRY_IN_EN adds a CarryIn port for the initial ADD/SUB carry.
module alu_mp_sequencer #(
  parameter int DataWidth = 8,
  parameter int Words     = 2,
  parameter int FlagBits  = 4
) (
  input  logic                         Clk,
  input  logic                         Reset_N,
  input  logic                         Start,
  input  logic [2:0]                   Op,
  input  logic [Words*DataWidth-1:0]   OpA,
  input  logic [Words*DataWidth-1:0]   OpB,
`ifdef ALU_SEQ_CARRY_IN_EN
  input  logic                         CarryIn,
`endif
  output logic                         Ready,
  output logic                         Valid,
  input  logic                         Ack,
  output logic [Words*DataWidth-1:0]   Result,
  output logic [FlagBits-1:0]          ResultFlags,
  output logic                         Error,
  output logic [DataWidth-1:0]         AluA,
  output logic [DataWidth-1:0]         AluB,
  output logic [3:0]                   AluFuncOp,
  output logic [FlagBits-1:0]          AluIFlags,
  input  logic [DataWidth-1:0]         AluY,
  input  logic [FlagBits-1:0]          AluOFlags
);

  localparam int TotW = Words * DataWidth;
  localparam int IdxW = (Words > 1) ? $clog2(Words) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  logic [1:0]          state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                zacc_q, zacc_d;
  logic [2:0]          op_q, op_d;
  logic [TotW-1:0]     a_q, a_d, b_q, b_d;
  logic [TotW-1:0]     result_q, result_d;
  logic [FlagBits-1:0] flags_q, flags_d;
  logic                error_q, error_d;

  logic                 is_logic;
  logic                 last_word;
  logic                 init_carry;
  logic [DataWidth-1:0] a_word, b_word;

  assign is_logic  = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);
  assign last_word = (idx_q == IdxW'(Words - 1));

`ifdef ALU_SEQ_CARRY_IN_EN
  assign init_carry = ((Op == OP_ADD) || (Op == OP_SUB)) ? CarryIn : 1'b0;
`else
  assign init_carry = (Op == OP_SUB);
`endif

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int w = 0; w < Words; w++) begin
      if (idx_q == IdxW'(w)) begin
        a_word = a_q[w*DataWidth +: DataWidth];
        b_word = b_q[w*DataWidth +: DataWidth];
      end
    end
  end

  // SUB runs on the ALU's Add as A + ~B + carry, so the Sub encoding is never driven.
  always_comb begin
    AluA      = '0;
    AluB      = '0;
    AluFuncOp = 4'b0000;
    AluIFlags = '0;
    if (state_q == S_RUN) begin
      AluA         = a_word;
      AluB         = (op_q == OP_SUB) ? ~b_word : b_word;
      AluIFlags[1] = carry_q;
      case (op_q)
        OP_AND:  AluFuncOp = 4'b0010;
        OP_OR:   AluFuncOp = 4'b0011;
        OP_XOR:  AluFuncOp = 4'b0100;
        default: AluFuncOp = 4'b0000;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          a_d      = OpA;
          b_d      = OpB;
          op_d     = Op;
          idx_d    = '0;
          zacc_d   = 1'b1;
          result_d = '0;
          flags_d  = '0;
          if (Op <= OP_XOR) begin
            carry_d = init_carry;
            error_d = 1'b0;
            state_d = S_RUN;
          end else begin
            carry_d = 1'b0;
            error_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        for (int w = 0; w < Words; w++) begin
          if (idx_q == IdxW'(w)) begin
            result_d[w*DataWidth +: DataWidth] = AluY;
          end
        end
        carry_d = is_logic ? 1'b0 : AluOFlags[1];
        zacc_d  = zacc_q & AluOFlags[0];
        idx_d   = idx_q + 1'b1;
        if (last_word) begin
          idx_d      = '0;
          state_d    = S_DONE;
          flags_d    = '0;
          flags_d[3] = ~is_logic & AluOFlags[3];
          flags_d[2] = AluOFlags[2];
          flags_d[1] = carry_d;
          flags_d[0] = zacc_d;
        end
      end
      S_DONE: begin
        if (Ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      error_q  <= error_d;
    end
  end

  assign Ready       = (state_q == S_IDLE);
  assign Valid       = (state_q == S_DONE);
  assign Result      = result_q;
  assign ResultFlags = flags_q;
  assign Error       = error_q;

endmodule

// File: doc/alu_mp_sequencer.md
Name: alu_mp_sequencer

Overview:
- Multi-precision front end that drives the team's combinational 8-bit ALU from the initiator side.
- Accepts a Words×DataWidth operation request over a Start/Ready handshake, issues one ALU word operation per clock from LSW to MSW, and chains the carry through the ALU's IFlags input.
- Assembles the full-width result and aggregate V/N/C/Z flags, then holds them until acknowledged.
- Sits between the control unit and the ALU instance.

Parameters:
- DataWidth, 8, ALU word width in bits.
- Words, 2, number of ALU words per operand (≥1).
- FlagBits, 4, flag vector width; bit order V,N,C,Z = 3,2,1,0.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Reset_N  in  1  synchronous active-low reset, sampled on rising Clk.
- Start  in  1  request strobe; accepted only when Ready=1.
- Op  in  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR; 5-7 illegal.
- OpA  in  Words*DataWidth  operand A.
- OpB  in  Words*DataWidth  operand B.
- Ready  out  1  high only in IDLE.
- Valid  out  1  result available; held until Ack.
- Ack  in  1  consumer accepts result; effective only while Valid=1.
- Result  out  Words*DataWidth  assembled result.
- ResultFlags  out  FlagBits  aggregate {V,N,C,Z}.
- Error  out  1  illegal Op; valid with Valid.
- AluA  out  DataWidth  ALU A input.
- AluB  out  DataWidth  ALU B input.
- AluFuncOp  out  4  ALU FuncOp: 0000 Add, 0010 And, 0011 Or, 0100 Xor.
- AluIFlags  out  FlagBits  ALU IFlags; only bit 1 (carry) is non-zero.
- AluY  in  DataWidth  ALU result.
- AluOFlags  in  FlagBits  ALU flags {V,N,C,Z}.

Behaviour:
- States:
  - IDLE: Ready=1.
  - RUN: one word per cycle.
  - DONE: Valid=1.
- Reset values, and reset at any point including mid-RUN: state=IDLE; Ready=1; Valid=0; Error=0; Result=0; ResultFlags=0; word index=0; carry=0.
- IDLE → RUN on an edge with Start=1:
  - OpA, OpB and Op are latched.
  - Index=0.
  - Z accumulator=1.
  - Carry register: ADD=0, SUB=1, logic ops=0.
- Illegal Op: IDLE → DONE directly; Error=1, Result=0, ResultFlags=0.
- Start while not IDLE: ignored; latched operands are never disturbed.
- RUN, combinational drive:
  - AluA = latched A word[index].
  - AluB = B word[index], or ~B word[index] for SUB.
  - AluIFlags = {2'b00, carry, 1'b0}.
  - AluFuncOp: ADD/SUB → Add (0000), so SUB is executed as A + ~B + 1 with a chained carry. The ALU's Sub op is never used.
- RUN, each edge:
  - Result word[index] ← AluY.
  - carry ← AluOFlags[1] (logic ops: forced 0).
  - Z accumulator &= AluOFlags[0].
  - index++.
- On the edge where index == Words-1:
  - State → DONE.
  - ResultFlags = {AluOFlags[3], AluOFlags[2], final carry, Zacc & AluOFlags[0]}; V and N are taken from the MSW only.
  - For logic ops, C=0 and V=0.
- Latency: Valid rises exactly Words cycles after the Start edge (1 cycle for an illegal Op).
- SUB carry semantics: C=1 means no borrow.
- DONE → IDLE on an edge with Ack=1. Ready returns the cycle after Ack. Result and ResultFlags stay stable until the next accepted Start.
- Outside RUN: AluA=0, AluB=0, AluFuncOp=0000, AluIFlags=0.
- Words=1: RUN lasts exactly one cycle.
- Index wraps to 0 on leaving RUN.

Optional Feature:
- Macro: ALU_SEQ_CARRY_IN_EN.
- Defined:
  - Adds input CarryIn (1 bit), latched with Start.
  - The initial carry for ADD and SUB is CarryIn, enabling chained multi-request arithmetic (SUB: CarryIn=1 means no borrow in).
  - Logic ops ignore CarryIn.
- Undefined: no port; initial carry is fixed as described in Behaviour.

Test Plan (DataWidth=8, Words=2):
- ADD 0x00FF + 0x0001 → Result 0x0100, flags V0 N0 C0 Z0; AluIFlags carry bit = 1 in cycle 2; Valid exactly 2 cycles after Start.
- ADD 0xFFFF + 0x0001 → 0x0000, C1 Z1 N0 V0. Also ADD 0x7FFF + 0x0001 → 0x8000, V1 N1 C0 Z0.
- SUB 0x0000 - 0x0001 → 0xFFFF, C0 N1 Z0. SUB 0x1234 - 0x1234 → 0x0000, C1 Z1.
- XOR 0xF0F0 ^ 0xFFFF → 0x0F0F, C0 V0; AluFuncOp=0100 during RUN. Op=7 → Valid after 1 cycle, Error1, Result 0.
- Handshake: hold Ack=0 for 5 cycles → Result stable and Valid held; Start pulses during RUN/DONE ignored; Ack → Ready=1 next cycle.
- Reset_N=0 during the first RUN cycle → next edge IDLE, Result 0, Valid 0. A new ADD then completes correctly. With ALU_SEQ_CARRY_IN_EN: ADD 0x0000 + 0x0000 with CarryIn=1 → 0x0001.
